// File: rtl/elevator_scheduler.sv
// elevator_scheduler: latches per-floor calls and dispatches the car one
// target at a time using a SCAN (sweep) policy. Emergency stop freezes
// dispatch while still collecting calls.
module elevator_scheduler #(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned DWELL      = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic                  emergency_stop,
  input  logic [1:0]            current_floor,
  input  logic                  door_open,
  output logic [NUM_FLOORS-1:0] floor_request,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_ARRIVE,
    S_SERVICE,
    S_HALT
  } state_t;

  state_t                  state;
  logic [1:0]              target;
  logic [7:0]              cnt;

  logic                    arrived;
  logic                    wait_expired;
  logic                    dwell_done;
  logic [NUM_FLOORS-1:0]   clear_mask;
  logic [1:0]              sel_target;
  logic                    sel_dir_up;
  logic [NUM_FLOORS-1:0]   sel_onehot;
  logic                    found_near;
  logic [1:0]              near_t;
  logic [1:0]              far_t;

  assign arrived      = (current_floor == target) && door_open;
  assign wait_expired = (cnt == 8'(TIMEOUT - 1));
  assign dwell_done   = (cnt == 8'(DWELL - 1));

  // SCAN choice: nearest pending floor in the sweep direction, else reverse.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    found_near = 1'b0;
    near_t     = '0;
    far_t      = '0;
    if (dir_up) begin
      // Descending scan: the last hit is the lowest floor at or above the car.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (pending[i] && (2'(i) >= current_floor)) begin
          near_t     = 2'(i);
          found_near = 1'b1;
        end
      end
      // Ascending scan: the last hit is the highest floor below the car.
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pending[i] && (2'(i) < current_floor)) far_t = 2'(i);
      end
    end else begin
      // Ascending scan: the last hit is the highest floor at or below the car.
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pending[i] && (2'(i) <= current_floor)) begin
          near_t     = 2'(i);
          found_near = 1'b1;
        end
      end
      // Descending scan: the last hit is the lowest floor above the car.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (pending[i] && (2'(i) > current_floor)) far_t = 2'(i);
      end
    end
    sel_target = found_near ? near_t : far_t;
    sel_dir_up = found_near ? dir_up : ~dir_up;
    sel_onehot = '0;
    sel_onehot[sel_target] = 1'b1;
  end

  // Served (or abandoned) call bit; emergency stop suppresses any clear.
  always_comb begin
    clear_mask = '0;
    if ((state == S_WAIT_ARRIVE) && !emergency_stop && (arrived || wait_expired)) begin
      clear_mask = floor_request;
    end
  end

  // Dispatch FSM with registered outputs and the pending-call latch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: every register, pending included, has an explicit reset; there is no memory array here.
      state         <= S_IDLE;
      pending       <= '0;
      floor_request <= '0;
      dir_up        <= 1'b1;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      target        <= '0;
      cnt           <= '0;
    end else begin
      pending <= (pending | call_btn) & ~clear_mask;

      if (emergency_stop) begin
        state         <= S_HALT;
        floor_request <= '0;
        cnt           <= '0;
        busy          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (|pending) begin
              state <= S_SELECT;
              busy  <= 1'b1;
            end
          end

          S_SELECT: begin
            if (|pending) begin
              target        <= sel_target;
              dir_up        <= sel_dir_up;
              floor_request <= sel_onehot;
              cnt           <= '0;
              state         <= S_WAIT_ARRIVE;
              busy          <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end

          S_WAIT_ARRIVE: begin
            if (arrived) begin
              floor_request <= '0;
              cnt           <= '0;
              state         <= S_SERVICE;
            end else if (wait_expired) begin
              timeout_err   <= 1'b1;
              floor_request <= '0;
              cnt           <= '0;
              state         <= S_IDLE;
              busy          <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end

          S_SERVICE: begin
            if (dwell_done) begin
              cnt <= '0;
              if (|pending) begin
                state <= S_SELECT;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end

          S_HALT: begin
            if (|pending) begin
              state <= S_SELECT;
              busy  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end

          default: begin
            state         <= S_IDLE;
            floor_request <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Call-collection and dispatch controller that sits in front of `elevator_design` and sequences it. It latches per-floor call buttons into a pending register and picks the next target floor with a SCAN (sweep) policy. It drives the car's one-hot `floor_request`, waits for arrival (floor match plus door open), then clears the served call. Emergency stop freezes dispatch without losing pending calls.

## Interface
- `NUM_FLOORS`, 4, floor count; fixed at 4 in this revision, with 2-bit floor index.
- `DWELL`, 8, cycles held in SERVICE after arrival before the next selection; valid range 1..255.
- `TIMEOUT`, 64, max cycles in WAIT_ARRIVE before abort; valid range 2..255.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `call_btn`  in  4  per-floor call pulses; any number of bits may be set; bit i = floor i.
- `emergency_stop`  in  1  level; while high the scheduler is in HALT.
- `current_floor`  in  2  car position from `elevator_design`.
- `door_open`  in  1  car door status from `elevator_design`.
- `floor_request`  out  4  one-hot target to the car; 0 when no dispatch is active.
- `pending`  out  4  latched unserved calls.
- `dir_up`  out  1  sweep direction: 1 = up, 0 = down.
- `busy`  out  1  high in SELECT, WAIT_ARRIVE and SERVICE.
- `timeout_err`  out  1  sticky; set on any arrival timeout; cleared only by `rst`.

## Operation
- States:
  - IDLE: wait for calls.
  - SELECT: compute the target floor.
  - WAIT_ARRIVE: drive `floor_request`, wait for the car.
  - SERVICE: door dwell.
  - HALT: emergency stop.
- Call latch: every cycle, `pending <= (pending | call_btn) & ~clear_mask`.
  - `clear_mask` is the one-hot target, only in the arrival cycle.
  - On that cycle clearing beats a simultaneous `call_btn` for the same floor.
  - Other bits set normally.
- IDLE -> SELECT when `pending != 0`.
- SELECT target rule, evaluated on registered `pending` and `current_floor`:
  - If `dir_up`: lowest pending floor >= current_floor; if none, highest pending floor below it, and `dir_up <= 0`.
  - If `!dir_up`: highest pending floor <= current_floor; if none, lowest pending floor above it, and `dir_up <= 1`.
  - Target equal to `current_floor` leaves `dir_up` unchanged.
  - Target is registered; next state is WAIT_ARRIVE.
- WAIT_ARRIVE: `floor_request = 1 << target`, held constant. The wait counter increments each cycle.
  - Arrival: `current_floor == target && door_open`. On arrival, clear `pending[target]`, zero `floor_request` and the counter, and go to SERVICE.
  - Counter reaching TIMEOUT-1 without arrival: set `timeout_err`, clear `pending[target]`, and go to IDLE.
- SERVICE: count DWELL cycles. Then go to SELECT if `pending != 0`, else IDLE.
- New calls never retarget an in-flight WAIT_ARRIVE. They are only considered at the next SELECT.
- HALT:
  - Entered from any state when `emergency_stop` is high. This has priority over all other transitions, including arrival in the same cycle; that arrival is not recorded.
  - In HALT: `floor_request = 0`, counters cleared, `pending` keeps accumulating, `busy = 0`.
  - On release, go to SELECT if `pending != 0`, else IDLE. The interrupted target is re-selected by the normal rule.
- `rst` has priority over `emergency_stop`.

## Timing
- Reset values:
  - state IDLE
  - `pending` 0
  - `floor_request` 0
  - `dir_up` 1
  - `busy` 0
  - `timeout_err` 0
  - target 0
  - counters 0
- `call_btn` sampled at edge N gives `pending` bit set after edge N, visible in cycle N+1.
- From IDLE: SELECT in cycle N+2, `floor_request` valid in cycle N+3.
- Arrival detected at edge M gives `floor_request = 0` and the `pending` bit cleared from cycle M+1, then DWELL cycles in SERVICE.
- Timeout: exactly TIMEOUT cycles of `floor_request` asserted before the abort, then IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- `rst` asserted mid-operation returns all registers to reset values on the next edge. `floor_request` is 0 from the following cycle.

## Test plan
- Single call: reset, car at floor 0, `call_btn=4'b1000` for 1 cycle.
  - Required: `floor_request=4'b1000` 3 cycles later, `dir_up=1`.
  - Drive `current_floor=3`, `door_open=1`: `pending` goes to 0, SERVICE for 8 cycles, then IDLE with `busy=0`.
- SCAN order: car at 1, `dir_up=1`, `call_btn=4'b1101` in one cycle.
  - Required targets in order: 2, 3, then 0, with `dir_up` dropping to 0 before floor 0 is dispatched.
- Emergency mid-dispatch: target 3 in WAIT_ARRIVE; pulse `emergency_stop` for 2 cycles while `call_btn=4'b0010`.
  - Required: `floor_request=0` during HALT, `pending=4'b1010` retained.
  - After release, SELECT re-dispatches floor 3 first (`dir_up=1`).
- Timeout: dispatch floor 2 and never signal arrival.
  - Required: after 64 cycles, `timeout_err=1`, `pending[2]=0`, state IDLE. `timeout_err` stays 1 through later normal service.
- Same-cycle clear/set: on the arrival cycle for floor 2, assert `call_btn=4'b0110`.
  - Required: `pending=4'b0010` afterwards, with floor 2 cleared and floor 1 set.
- Reset mid-operation: assert `rst` in WAIT_ARRIVE with `pending=4'b1111`.
  - Required: next cycle shows `pending=0`, `floor_request=0`, `dir_up=1`, `busy=0`.
